// File: rtl/fixed_div_sqrt.sv
// Fixed-point signed divider (restoring, 1 bit/cycle) and unsigned square root (2 bits/cycle).
// Define FIXED_DIV_SQRT_SQRT_EN to build the square-root unit; otherwise its outputs are tied low.
module fixed_div_sqrt #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic [WIDTH-1:0] div_a,
  input  logic [WIDTH-1:0] div_b,
  output logic             div_done,
  output logic             div_valid,
  output logic [WIDTH-1:0] div_val,
  input  logic             sqrt_start,
  input  logic [WIDTH-1:0] sqrt_rad,
  output logic [WIDTH-1:0] sqrt_root,
  output logic             sqrt_valid
);

  localparam int N   = WIDTH + FBITS;
  localparam int H   = N / 2;
  localparam int DCW = $clog2(N);
  localparam int SCW = $clog2(H);
  localparam logic [DCW-1:0] DLAST = DCW'(N - 1);
  localparam logic [SCW-1:0] SLAST = SCW'(H - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FINISH} state_t;

  // ---------------- divider ----------------
  state_t           dstate_q, dstate_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic [WIDTH-1:0] drem_q, drem_d;
  logic [N-1:0]     dquo_q, dquo_d;
  logic [WIDTH-1:0] dbv_q, dbv_d;
  logic             dneg_q, dneg_d;
  logic             dbz_q, dbz_d;
  logic             dfin_q, dfin_d;
  logic             dok_q, dok_d;
  logic [WIDTH-1:0] dres_q, dres_d;
  logic             div_done_q, div_done_d;
  logic             div_valid_q, div_valid_d;
  logic [WIDTH-1:0] div_val_q, div_val_d;

  logic [WIDTH-1:0] a_mag, b_mag, q_mag;
  logic [WIDTH:0]   d_shift, d_diff;
  logic             d_ovf, d_ok;

  always_comb begin
    dstate_d    = dstate_q;
    dcnt_d      = dcnt_q;
    drem_d      = drem_q;
    dquo_d      = dquo_q;
    dbv_d       = dbv_q;
    dneg_d      = dneg_q;
    dbz_d       = dbz_q;
    dok_d       = dok_q;
    dres_d      = dres_q;
    dfin_d      = 1'b0;
    div_done_d  = dfin_q;
    div_valid_d = div_valid_q;
    div_val_d   = div_val_q;

    a_mag   = div_a[WIDTH-1] ? (~div_a + 1'b1) : div_a;
    b_mag   = div_b[WIDTH-1] ? (~div_b + 1'b1) : div_b;
    d_shift = {drem_q, dquo_q[N-1]};
    d_diff  = d_shift - {1'b0, dbv_q};
    q_mag   = dquo_q[WIDTH-1:0];
    // The negative range reaches one step further than the positive range.
    d_ovf   = (|dquo_q[N-1:WIDTH]) ||
              (q_mag[WIDTH-1] && (!dneg_q || (|q_mag[WIDTH-2:0])));
    d_ok    = !dbz_q && !d_ovf;

    if (dfin_q) begin
      div_val_d   = dres_q;
      div_valid_d = dok_q;
    end

    case (dstate_q)
      ST_IDLE: begin
        if (div_start) begin
          dquo_d   = {a_mag, {FBITS{1'b0}}};
          dbv_d    = b_mag;
          drem_d   = '0;
          dneg_d   = div_a[WIDTH-1] ^ div_b[WIDTH-1];
          dbz_d    = (div_b == '0);
          dcnt_d   = '0;
          dstate_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (!d_diff[WIDTH]) begin
          drem_d = d_diff[WIDTH-1:0];
          dquo_d = {dquo_q[N-2:0], 1'b1};
        end else begin
          drem_d = d_shift[WIDTH-1:0];
          dquo_d = {dquo_q[N-2:0], 1'b0};
        end
        if (dcnt_q == DLAST) begin
          dstate_d = ST_FINISH;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_FINISH: begin
        dok_d    = d_ok;
        dres_d   = d_ok ? (dneg_q ? (~q_mag + 1'b1) : q_mag) : '0;
        dfin_d   = 1'b1;
        dstate_d = ST_IDLE;
      end
      default: dstate_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dstate_q    <= ST_IDLE;
      dcnt_q      <= '0;
      drem_q      <= '0;
      dquo_q      <= '0;
      dbv_q       <= '0;
      dneg_q      <= 1'b0;
      dbz_q       <= 1'b0;
      dfin_q      <= 1'b0;
      dok_q       <= 1'b0;
      dres_q      <= '0;
      div_done_q  <= 1'b0;
      div_valid_q <= 1'b0;
      div_val_q   <= '0;
    end else begin
      dstate_q    <= dstate_d;
      dcnt_q      <= dcnt_d;
      drem_q      <= drem_d;
      dquo_q      <= dquo_d;
      dbv_q       <= dbv_d;
      dneg_q      <= dneg_d;
      dbz_q       <= dbz_d;
      dfin_q      <= dfin_d;
      dok_q       <= dok_d;
      dres_q      <= dres_d;
      div_done_q  <= div_done_d;
      div_valid_q <= div_valid_d;
      div_val_q   <= div_val_d;
    end
  end

  assign div_done  = div_done_q;
  assign div_valid = div_valid_q;
  assign div_val   = div_val_q;

  // ---------------- square root ----------------
`ifdef FIXED_DIV_SQRT_SQRT_EN
  state_t           sstate_q, sstate_d;
  logic [SCW-1:0]   scnt_q, scnt_d;
  logic [N-1:0]     sx_q, sx_d;
  logic [H-1:0]     srem_q, srem_d;
  logic [H-1:0]     sroot_q, sroot_d;
  logic [WIDTH-1:0] sqrt_root_q, sqrt_root_d;
  logic             sqrt_valid_q, sqrt_valid_d;

  logic [H+1:0]     s_rt, s_trial, s_diff;

  always_comb begin
    sstate_d     = sstate_q;
    scnt_d       = scnt_q;
    sx_d         = sx_q;
    srem_d       = srem_q;
    sroot_d      = sroot_q;
    sqrt_root_d  = sqrt_root_q;
    sqrt_valid_d = 1'b0;

    // The partial remainder never exceeds H bits before the final step.
    s_rt    = {srem_q, sx_q[N-1:N-2]};
    s_trial = {sroot_q, 2'b01};
    s_diff  = s_rt - s_trial;

    case (sstate_q)
      ST_IDLE: begin
        if (sqrt_start) begin
          sx_d     = {sqrt_rad, {FBITS{1'b0}}};
          srem_d   = '0;
          sroot_d  = '0;
          scnt_d   = '0;
          sstate_d = ST_CALC;
        end
      end
      ST_CALC: begin
        sx_d = {sx_q[N-3:0], 2'b00};
        if (s_rt >= s_trial) begin
          srem_d  = s_diff[H-1:0];
          sroot_d = {sroot_q[H-2:0], 1'b1};
        end else begin
          srem_d  = s_rt[H-1:0];
          sroot_d = {sroot_q[H-2:0], 1'b0};
        end
        if (scnt_q == SLAST) begin
          sstate_d = ST_FINISH;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      ST_FINISH: begin
        sqrt_root_d  = {{(WIDTH-H){1'b0}}, sroot_q};
        sqrt_valid_d = 1'b1;
        sstate_d     = ST_IDLE;
      end
      default: sstate_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sstate_q     <= ST_IDLE;
      scnt_q       <= '0;
      sx_q         <= '0;
      srem_q       <= '0;
      sroot_q      <= '0;
      sqrt_root_q  <= '0;
      sqrt_valid_q <= 1'b0;
    end else begin
      sstate_q     <= sstate_d;
      scnt_q       <= scnt_d;
      sx_q         <= sx_d;
      srem_q       <= srem_d;
      sroot_q      <= sroot_d;
      sqrt_root_q  <= sqrt_root_d;
      sqrt_valid_q <= sqrt_valid_d;
    end
  end

  assign sqrt_root  = sqrt_root_q;
  assign sqrt_valid = sqrt_valid_q;
`else
  logic sqrt_unused;
  assign sqrt_unused = ^{sqrt_start, sqrt_rad};
  assign sqrt_root   = '0;
  assign sqrt_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_fixed_div_sqrt.sv
// Directed, table-driven bench for fixed_div_sqrt (WIDTH=32, FBITS=16).
module tb_fixed_div_sqrt;

  localparam int W = 32;
  localparam int LDIV = 50;
  localparam int LSQ  = 25;
`ifdef FIXED_DIV_SQRT_SQRT_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         div_start = 1'b0;
  logic [W-1:0] div_a = '0, div_b = '0;
  logic         div_done, div_valid;
  logic [W-1:0] div_val;
  logic         sqrt_start = 1'b0;
  logic [W-1:0] sqrt_rad = '0;
  logic [W-1:0] sqrt_root;
  logic         sqrt_valid;

  fixed_div_sqrt #(.WIDTH(32), .FBITS(16)) dut (
    .clk(clk), .rst(rst),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_valid(div_valid), .div_val(div_val),
    .sqrt_start(sqrt_start), .sqrt_rad(sqrt_rad),
    .sqrt_root(sqrt_root), .sqrt_valid(sqrt_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, q;
    logic         v;
    logic [W-1:0] rad, root;
  } vec_t;

  int passed = 0;
  int total  = 0;

  int           d_cnt, d_cyc, s_cnt, s_cyc;
  logic [W-1:0] d_val, s_root;
  logic         d_valid;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Present operands now; the next rising edge samples the start strobes.
  task automatic launch(input logic ds, input logic ss, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] rad);
    div_a = a; div_b = b; div_start = ds;
    sqrt_rad = rad; sqrt_start = ss;
    @(posedge clk); #1;
    div_start = 1'b0; sqrt_start = 1'b0;
    div_a = 32'hDEADBEEF; div_b = 32'h1234_5678; sqrt_rad = 32'hA5A5_A5A5;
  endtask

  // Watch n cycles; optionally re-strobe div_start at cycle inj.
  task automatic monitor(input int n, input int inj);
    d_cnt = 0; d_cyc = 0; s_cnt = 0; s_cyc = 0;
    d_val = '0; d_valid = 1'b0; s_root = '0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (c == inj) begin
        div_a = 32'h0010_0000; div_b = 32'h0001_0000; div_start = 1'b1;
      end else begin
        div_start = 1'b0;
      end
      if (div_done) begin
        d_cnt++;
        if (d_cnt == 1) begin d_cyc = c; d_val = div_val; d_valid = div_valid; end
      end
      if (sqrt_valid) begin
        s_cnt++;
        if (s_cnt == 1) begin s_cyc = c; s_root = sqrt_root; end
      end
    end
    div_start = 1'b0;
  endtask

  vec_t vt [11];

  initial begin
    vt[0]  = '{32'h001B0000, 32'h00030000, 32'h00090000, 1'b1, 32'h00024000, 32'h00018000};
    vt[1]  = '{32'hFFF88000, 32'h00020000, 32'hFFFC4000, 1'b1, 32'h00020000, 32'h00016A09};
    vt[2]  = '{32'h00050000, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000};
    vt[3]  = '{32'h7FFF0000, 32'h00000001, 32'h00000000, 1'b0, 32'h00010000, 32'h00010000};
    vt[4]  = '{32'h00010000, 32'h00030000, 32'h00005555, 1'b1, 32'hFFFFFFFF, 32'h00FFFFFF};
    vt[5]  = '{32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 1'b1, 32'h00000001, 32'h00000100};
    vt[6]  = '{32'h80000000, 32'h00010000, 32'h80000000, 1'b1, 32'h00090000, 32'h00030000};
    vt[7]  = '{32'h80000000, 32'hFFFF0000, 32'h00000000, 1'b0, 32'h00000002, 32'h0000016A};
    vt[8]  = '{32'hFFFFFFFF, 32'h00020000, 32'h00000000, 1'b1, 32'h00640000, 32'h000A0000};
    vt[9]  = '{32'h00000000, 32'h00050000, 32'h00000000, 1'b1, 32'h00004000, 32'h00008000};
    vt[10] = '{32'hFFFA0000, 32'hFFFE0000, 32'h00030000, 1'b1, 32'h7FFFFFFF, 32'h00B504F3};

    // Reset with starts asserted: nothing may start.
    div_start = 1'b1; sqrt_start = 1'b1; div_a = 32'h001B0000; div_b = 32'h00030000;
    sqrt_rad = 32'h00024000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_div_done", {31'd0, div_done}, 32'd0);
    check("rst_div_valid", {31'd0, div_valid}, 32'd0);
    check("rst_div_val", div_val, 32'd0);
    check("rst_sqrt_valid", {31'd0, sqrt_valid}, 32'd0);
    check("rst_sqrt_root", sqrt_root, 32'd0);
    rst = 1'b0; div_start = 1'b0; sqrt_start = 1'b0;
    monitor(60, 0);
    check("rst_start_ignored_div", d_cnt, 0);
    check("rst_start_ignored_sqrt", s_cnt, 0);

    // Table: each divide runs concurrently with a square root.
    for (int i = 0; i < 11; i++) begin
      launch(1'b1, 1'b1, vt[i].a, vt[i].b, vt[i].rad);
      monitor(70, 0);
      $display("vec %0d: div 0x%08h/0x%08h -> 0x%08h v=%0d @%0d | sqrt 0x%08h -> 0x%08h @%0d",
               i, vt[i].a, vt[i].b, d_val, d_valid, d_cyc, vt[i].rad, s_root, s_cyc);
      check($sformatf("v%0d_div_lat", i), d_cyc, LDIV);
      check($sformatf("v%0d_div_cnt", i), d_cnt, 1);
      check($sformatf("v%0d_div_val", i), d_val, vt[i].q);
      check($sformatf("v%0d_div_valid", i), {31'd0, d_valid}, {31'd0, vt[i].v});
      check($sformatf("v%0d_div_held", i), div_val, vt[i].q);
      check($sformatf("v%0d_sqrt_lat", i), s_cyc, SQ ? LSQ : 0);
      check($sformatf("v%0d_sqrt_cnt", i), s_cnt, SQ ? 1 : 0);
      check($sformatf("v%0d_sqrt_root", i), s_root, SQ ? vt[i].root : 32'd0);
      check($sformatf("v%0d_sqrt_held", i), sqrt_root, SQ ? vt[i].root : 32'd0);
    end

    // Abort both units with reset sampled on cycle 10; start held during reset.
    launch(1'b1, 1'b1, 32'h001B0000, 32'h00030000, 32'h00020000);
    monitor(9, 0);
    rst = 1'b1; div_start = 1'b1; sqrt_start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; div_start = 1'b0; sqrt_start = 1'b0;
    check("abort_div_val", div_val, 32'd0);
    check("abort_div_valid", {31'd0, div_valid}, 32'd0);
    check("abort_sqrt_root", sqrt_root, 32'd0);
    monitor(70, 0);
    $display("abort: div pulses %0d sqrt pulses %0d", d_cnt, s_cnt);
    check("abort_div_pulses", d_cnt, 0);
    check("abort_sqrt_pulses", s_cnt, 0);
    launch(1'b1, 1'b1, 32'hFFF88000, 32'h00020000, 32'h00024000);
    monitor(70, 0);
    $display("restart: div 0x%08h @%0d sqrt 0x%08h @%0d", d_val, d_cyc, s_root, s_cyc);
    check("restart_div_lat", d_cyc, LDIV);
    check("restart_div_val", d_val, 32'hFFFC4000);
    check("restart_sqrt_lat", s_cyc, SQ ? LSQ : 0);
    check("restart_sqrt_root", s_root, SQ ? 32'h00018000 : 32'd0);

    // Busy divider ignores a second start at cycle 5.
    launch(1'b1, 1'b0, 32'h001B0000, 32'h00030000, 32'h0);
    monitor(110, 5);
    $display("busy: div pulses %0d first 0x%08h @%0d", d_cnt, d_val, d_cyc);
    check("busy_div_cnt", d_cnt, 1);
    check("busy_div_lat", d_cyc, LDIV);
    check("busy_div_val", d_val, 32'h00090000);

    // Back-to-back: start again right after the completion pulse.
    launch(1'b1, 1'b0, 32'h00010000, 32'h00030000, 32'h0);
    monitor(LDIV, 0);
    check("b2b_div_first", d_val, 32'h00005555);
    launch(1'b1, 1'b0, 32'h001B0000, 32'h00030000, 32'h0);
    monitor(70, 0);
    $display("b2b div: 0x%08h @%0d", d_val, d_cyc);
    check("b2b_div_lat", d_cyc, LDIV);
    check("b2b_div_val", d_val, 32'h00090000);
    launch(1'b0, 1'b1, 32'h0, 32'h0, 32'h00024000);
    monitor(LSQ, 0);
    launch(1'b0, 1'b1, 32'h0, 32'h0, 32'h00090000);
    monitor(40, 0);
    $display("b2b sqrt: 0x%08h @%0d", s_root, s_cyc);
    check("b2b_sqrt_lat", s_cyc, SQ ? LSQ : 0);
    check("b2b_sqrt_root", s_root, SQ ? 32'h00030000 : 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fixed_div_sqrt.md
FIXED_DIV_SQRT -- requirements
Module: fixed_div_sqrt

Interface
REQ-001 Parameter WIDTH, default 32, total bits of every fixed-point operand and result.
REQ-002 Parameter FBITS, default 16, fractional bits; WIDTH+FBITS SHALL be even.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 div_start  in  1  request division; sampled only when divider idle.
REQ-007 div_a  in  WIDTH  signed dividend, two's complement QWIDTH-FBITS.FBITS.
REQ-008 div_b  in  WIDTH  signed divisor, same format.
REQ-009 div_done  out  1  one-cycle completion pulse.
REQ-010 div_valid  out  1  result legal; meaningful only with div_done.
REQ-011 div_val  out  WIDTH  signed quotient; held until next completion.
REQ-012 sqrt_start  in  1  request square root; sampled only when sqrt unit idle.
REQ-013 sqrt_rad  in  WIDTH  radicand, unsigned fixed-point, same FBITS.
REQ-014 sqrt_root  out  WIDTH  unsigned root; held until next completion.
REQ-015 sqrt_valid  out  1  one-cycle completion pulse.

Function
REQ-016 Divider and sqrt unit SHALL be independent; both may run concurrently.
REQ-017 Divider: operands captured on the edge sampling div_start; div_a/div_b may then change.
REQ-018 Divider SHALL compute (|a|<<FBITS)/|b| by restoring division, one quotient bit per cycle, WIDTH+FBITS iterations.
REQ-019 Quotient truncated toward zero; negated when sign(a) XOR sign(b); zero result never negative.
REQ-020 div_done SHALL pulse exactly L_div = WIDTH+FBITS+2 cycles after the div_start sampling edge, for every operand pair.
REQ-021 div_b = 0: div_done at L_div, div_valid = 0, div_val = 0.
REQ-022 Magnitude result not representable in signed WIDTH bits (overflow): div_valid = 0, div_val = 0.
REQ-023 Otherwise div_valid = 1 with div_done.
REQ-024 div_start while divider busy SHALL be ignored; no queuing.
REQ-025 Divider states: IDLE -> CALC (WIDTH+FBITS cycles) -> FINISH (sign/overflow fix, done pulse) -> IDLE.
REQ-026 Sqrt: radicand captured on sampling edge; root = floor(sqrt(rad << FBITS)), i.e. floor of the true fixed-point sqrt.
REQ-027 Sqrt SHALL use digit-by-digit method, two radicand bits per cycle, (WIDTH+FBITS)/2 iterations.
REQ-028 sqrt_valid SHALL pulse exactly L_sqrt = (WIDTH+FBITS)/2+1 cycles after sampling edge; sqrt_start while busy ignored.
REQ-029 sqrt_rad = 0 SHALL yield sqrt_root = 0 with valid at L_sqrt.
REQ-030 A new start on the same cycle a unit returns to IDLE SHALL be accepted.

Reset
REQ-031 rst SHALL abort any operation in either unit and return both to IDLE without a completion pulse.
REQ-032 Reset values: div_done=0, div_valid=0, div_val=0, sqrt_valid=0, sqrt_root=0.
REQ-033 start asserted during rst SHALL be ignored.

Configuration
REQ-034 Macro FIXED_DIV_SQRT_SQRT_EN: defined -> sqrt unit built as above.
REQ-035 Undefined -> sqrt logic absent; sqrt_root tied 0, sqrt_valid tied 0, sqrt inputs ignored; divider unchanged.

Verification (WIDTH=32, FBITS=16, macro defined)
REQ-036 div_a=0x001B0000, div_b=0x00030000 (27/3) -> div_val=0x00090000, div_valid=1, div_done 50 cycles after start.
REQ-037 div_a=0xFFF88000, div_b=0x00020000 (-7.5/2) -> div_val=0xFFFC4000, div_valid=1.
REQ-038 div_b=0 and div_a=0x7FFF0000/div_b=0x00000001 -> div_done at 50, div_valid=0, div_val=0.
REQ-039 sqrt_rad=0x00024000 -> sqrt_root=0x00018000 at 25 cycles; sqrt_rad=0x00020000 -> 0x00016A09.
REQ-040 Concurrent div+sqrt start, then rst at cycle 10 -> no pulses, outputs 0; restart completes normally.
REQ-041 Second div_start at cycle 5 of a division -> ignored; single div_done with first result.
